// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants and small types for the register-file read side.
//   RF_ADDR_WIDTH  default address width (storage depth = 2**RF_ADDR_WIDTH)
//   RF_DATA_WIDTH  default data word width
//   RSP_DEPTH      number of words the response buffer can hold
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_DATA_WIDTH = 8;
    localparam int RSP_DEPTH     = 2;

    // Occupancy counter for the response buffer; wide enough to hold RSP_DEPTH
    // plus the stage-1 word.
    typedef logic [1:0] rsp_cnt_t;

    // Buffer pointers wrap modulo 2, so advancing one is a simple inversion.
    function automatic logic rsp_ptr_next(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/rf_read_port_if.sv
// ---------------------------------------------------------------------------
// rf_read_port_if
// Request/response bundle between a read requester and rf_read_port.
//   req_valid/req_ready/req_addr   read request channel
//   rsp_valid/rsp_ready/rsp_data   read response channel
// Modports:
//   master  requester side (drives req_valid, req_addr, rsp_ready)
//   slave   rf_read_port side (drives req_ready, rsp_valid, rsp_data)
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. ready never depends on valid of the same
// channel. While valid is high and ready is low, the sender holds valid and its
// payload stable; after a transfer the sender may change the payload freely.
// ---------------------------------------------------------------------------
interface rf_read_port_if
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/rf_rsp_fifo.sv
// ---------------------------------------------------------------------------
// rf_rsp_fifo
// Two-entry synchronous FIFO holding read responses until the consumer takes
// them. Head word is presented combinationally from registered storage.
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset (empties the FIFO, clears storage)
//   push       write push_data at the tail this cycle
//   push_data  word to enqueue
//   pop        drop the head word this cycle (caller guarantees count != 0)
//   head_data  current head word (0 after reset)
//   count      number of words held, 0..2
// ---------------------------------------------------------------------------
module rf_rsp_fifo
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output rsp_cnt_t              count
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    rsp_cnt_t              count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= rsp_ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= rsp_ptr_next(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // The top's request throttle keeps the buffer from ever overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'(RSP_DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// Read side of the write-only register file. Accepts read requests, issues a
// synchronous storage read, and returns the word on a response channel through
// a 2-entry buffer. The register-file write port is snooped so a read accepted
// in the same cycle as a write to the same address returns the new data.
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset; drops all in-flight reads
//   rd         request/response bundle (slave side)
//   mem_ren    storage read enable, high exactly on an accepted request
//   mem_raddr  storage read address (follows req_addr)
//   mem_rdata  storage read data, valid the cycle after mem_ren
//   wen        snooped register-file write enable
//   waddr      snooped write address
//   wdata      snooped write data
// ---------------------------------------------------------------------------
module rf_read_port
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_read_port_if.slave         rd,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic                  out_of_reset_q;
    logic                  s1_valid_q;
    logic                  s1_fwd_q;
    logic [DATA_WIDTH-1:0] s1_wdata_q;

    logic                  accept;
    logic                  fwd_hit;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] head_data;
    rsp_cnt_t              count;
    rsp_cnt_t              occupancy;

    // Words committed to the response path (buffer + stage 1), not counting a
    // word the consumer takes this cycle. Counting that departing word would
    // stall the pipeline every other cycle even with rsp_ready held high.
    always_comb begin
        occupancy = count + {1'b0, s1_valid_q} - {1'b0, pop};
    end

    assign pop          = (count != 2'd0) && rd.rsp_ready;
    assign rd.req_ready = out_of_reset_q && (occupancy < 2'(RSP_DEPTH));
    assign accept       = rd.req_valid && rd.req_ready;
    assign fwd_hit      = accept && wen && (waddr == rd.req_addr);

    assign mem_ren      = accept;
    assign mem_raddr    = rd.req_addr;

    // Storage is read-first, so a same-cycle write is only visible through the
    // latched snoop data. Writes after the accept cycle are never merged.
    assign push         = s1_valid_q;
    assign push_data    = s1_fwd_q ? s1_wdata_q : mem_rdata;

    assign rd.rsp_valid = (count != 2'd0);
    assign rd.rsp_data  = head_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset_q <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_fwd_q       <= 1'b0;
            s1_wdata_q     <= '0;
        end else begin
            out_of_reset_q <= 1'b1;
            s1_valid_q     <= accept;
            s1_fwd_q       <= fwd_hit;
            if (fwd_hit) begin
                s1_wdata_q <= wdata;
            end
        end
    end

    rf_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

endmodule
